pll_recfg_seq: RTL and testbench
================================

// Module: pll_recfg_seq
// PURPOSE
//  Sequences Avalon-MM writes into the PLL reconfig controller (pll_hdmi_cfg) to retune the SDRAM PLL:
//  M/K/N/C0/C1/CP/BW load, apply, PLL reset pulse, lock wait, then a relative phase step to a target.
//  Replaces the ad-hoc write FSM in the top level. Keyboard/auto-stepping logic issues one request per retune.
// PARAMETERS
//  GAP_CYCLES    7        idle cycles after each accepted write before the next one
//  RST_CYCLES    8        width of the pll_reset pulse, in clk cycles
//  LOCK_TIMEOUT  1000000  max cycles waiting for locked after reset; 0 disables the timeout
//  PH_W          16       width of phase values (phase steps)
// PORTS
//  clk               in   1     management clock (CLK_50M domain)
//  reset             in   1     synchronous, active-high
//  req               in   1     start pulse; sampled only in IDLE
//  phase_only        in   1     with req: skip the frequency load and do the phase step only
//  cfg_m             in   32    M counter word (reg 4)
//  cfg_k             in   32    fractional K word (reg 7)
//  cfg_c             in   32    C counter word; C0 = cfg_c, C1 = cfg_c | 'h40000 (reg 5)
//  cfg_phase         in   PH_W  target absolute phase, in steps
//  locked            in   1     PLL lock (synchronised externally)
//  mgmt_waitrequest  in   1     Avalon stall
//  mgmt_write        out  1     Avalon write strobe
//  mgmt_address      out  6     register address
//  mgmt_writedata    out  32    register data
//  pll_reset         out  1     PLL reset, ORed externally with RESET
//  busy              out  1     high from req acceptance until done
//  done              out  1     one-cycle pulse at the end of a sequence
//  err               out  1     sticky lock-timeout flag; cleared by the next accepted req
//  cur_phase         out  PH_W  phase currently applied to the PLL
// BEHAVIOUR
//  Reset: all outputs 0, cur_phase 0, state IDLE. Applies mid-sequence as well: write and pll_reset drop on the
//  next edge with no completion of the transfer. Reset at any time gives cur_phase 0.
//  IDLE: req=1 latches cfg_* and phase_only, clears err, and sets busy on the next cycle.
//    phase_only=0 -> FREQ step list; phase_only=1 -> PHASE step list.
//    req while busy is ignored (not queued).
//  Write handshake: address and data stay stable and mgmt_write=1 until a cycle where waitrequest=0 (accept).
//    After that: mgmt_write=0 for GAP_CYCLES, then the next step. There is no bound on waitrequest duration.
//  FREQ list, in order (addr:data):
//    0:0, 4:M, 7:K, 3:'h10000, 5:C, 5:C|'h40000, 9:1, 8:7, 2:0
//    Then PLLRST: pll_reset=1 for exactly RST_CYCLES.
//    Then WAIT_LOCK: advance on the first cycle with locked=1.
//    Lock timeout: cycle count reaches LOCK_TIMEOUT -> err=1, done pulse, IDLE. The phase step is skipped.
//    After lock: the PHASE list.
//  PHASE list:
//    delta = cfg_phase - cur_phase, computed at PH_W+1 bits signed.
//    delta==0: skip all writes, done pulse.
//    Otherwise writes 0:0; 6:|delta| | 'h10000 | (delta<0 ? 'h200000 : 0); 2:0.
//    cur_phase <= cfg_phase on acceptance of the address-2 write.
//  DONE: done=1 and busy=0 in the same cycle; IDLE on the next cycle. A req in that DONE cycle is ignored.
//  Latency (waitrequest=0, phase_only=1, delta!=0): req to done = 1 + 3*(1+GAP_CYCLES) + 1 cycles.
//  cur_phase is never modified by a failed (timeout) sequence.
// STRUCTURE
//  Shared package pll_recfg_pkg:
//    register address localparams: MODE=0, START=2, N=3, M=4, C=5, PHASE=6, K=7, BW=8, CP=9
//    bit constants: C1_SEL='h40000, PH_CNT_C0='h10000, PH_UP_DN='h200000
//    state enum: IDLE, ISSUE, GAP, PLLRST, WAIT_LOCK, DONE
//  The step list is a small combinational ROM indexed by a 4-bit step counter in this module; no sub-module.
//  Single shared down-counter for the gap, reset-pulse and timeout waits.
// TESTING
//  1. FREQ, waitrequest=0, cfg_m='h808, cfg_k='hB33332DD, cfg_c='h20302, cfg_phase=29
//     -> 9 writes in the listed order, 7-cycle gaps; 8-cycle pll_reset; then after lock the phase writes
//        6:'h1001D and 2:0; cur_phase=29; one done pulse.
//  2. phase_only, cur_phase=29, cfg_phase=20 -> 6:'h210009 written; cur_phase=20; done 26 cycles after req.
//  3. phase_only with cfg_phase==cur_phase -> no mgmt_write at all; done 2 cycles after req.
//  4. waitrequest held high for 50 cycles on the K write -> address 7 and data stable throughout;
//     exactly one acceptance; order otherwise unchanged.
//  5. locked kept low, LOCK_TIMEOUT=100 -> err=1 and done 100 cycles after pll_reset falls;
//     no address-6 write; cur_phase unchanged.
//  6. reset asserted during PLLRST, and separately a second req mid-sequence
//     -> reset: pll_reset/mgmt_write/busy=0 on the next edge;
//     -> second req: no effect on the write sequence.

Source files
------------

// File: rtl/pll_recfg_pkg.sv
// Shared register map, bit constants and sequencer types for the PLL reconfig controller.
package pll_recfg_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_PHASE = 6'd6;
    localparam logic [5:0] ADDR_K     = 6'd7;
    localparam logic [5:0] ADDR_BW    = 6'd8;
    localparam logic [5:0] ADDR_CP    = 6'd9;

    localparam logic [31:0] C1_SEL    = 32'h0004_0000;
    localparam logic [31:0] PH_CNT_C0 = 32'h0001_0000;
    localparam logic [31:0] PH_UP_DN  = 32'h0020_0000;
    localparam logic [31:0] N_BYPASS  = 32'h0001_0000;

    // Step ROM layout: 0..8 frequency load, 9..11 phase step, 12 = end of list
    localparam logic [3:0] STEP_PH0  = 4'd9;
    localparam logic [3:0] STEP_PH2  = 4'd11;
    localparam logic [3:0] STEP_END  = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        PLLRST,
        WAIT_LOCK,
        DONE
    } state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

endpackage

// File: rtl/pll_recfg_seq.sv
// Sequences Avalon-MM writes into the PLL reconfig controller: frequency load,
// PLL reset pulse, lock wait, then a relative phase step towards a target.
module pll_recfg_seq
    import pll_recfg_pkg::*;
#(
    parameter int GAP_CYCLES   = 7,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int PH_W         = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            phase_only,
    input  logic [31:0]     cfg_m,
    input  logic [31:0]     cfg_k,
    input  logic [31:0]     cfg_c,
    input  logic [PH_W-1:0] cfg_phase,
    input  logic            locked,
    input  logic            mgmt_waitrequest,
    output logic            mgmt_write,
    output logic [5:0]      mgmt_address,
    output logic [31:0]     mgmt_writedata,
    output logic            pll_reset,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [PH_W-1:0] cur_phase
);

    localparam logic [31:0] GAP_LD  = (GAP_CYCLES   > 0) ? 32'(GAP_CYCLES - 1)   : 32'd0;
    localparam logic [31:0] RST_LD  = (RST_CYCLES   > 0) ? 32'(RST_CYCLES - 1)   : 32'd0;
    localparam logic [31:0] LOCK_LD = (LOCK_TIMEOUT > 0) ? 32'(LOCK_TIMEOUT - 1) : 32'd0;

    state_t          state, state_nx;
    logic [3:0]      step, step_nx;
    logic [31:0]     cnt, cnt_nx;
    logic [31:0]     m_q, k_q, c_q;
    logic [PH_W-1:0] ph_q;
    logic            ph_mode;
    wr_t             wr;

    logic [PH_W:0]   delta, delta_neg;
    logic [PH_W-1:0] delta_abs;
    logic            delta_zero;
    logic [31:0]     ph_word;
    logic            accept, lock_ok, tmo;

    // Unsigned PH_W+1 subtraction has the same bit pattern as the signed difference
    assign delta      = {1'b0, ph_q} - {1'b0, cur_phase};
    assign delta_neg  = -delta;
    assign delta_abs  = delta[PH_W] ? delta_neg[PH_W-1:0] : delta[PH_W-1:0];
    assign delta_zero = (delta == '0);
    assign ph_word    = 32'(delta_abs) | PH_CNT_C0 | (delta[PH_W] ? PH_UP_DN : 32'd0);

    always_comb begin
        wr = '{addr: ADDR_MODE, data: 32'd0};
        case (step)
            4'd0:    wr = '{addr: ADDR_MODE,  data: 32'd0};
            4'd1:    wr = '{addr: ADDR_M,     data: m_q};
            4'd2:    wr = '{addr: ADDR_K,     data: k_q};
            4'd3:    wr = '{addr: ADDR_N,     data: N_BYPASS};
            4'd4:    wr = '{addr: ADDR_C,     data: c_q};
            4'd5:    wr = '{addr: ADDR_C,     data: c_q | C1_SEL};
            4'd6:    wr = '{addr: ADDR_CP,    data: 32'd1};
            4'd7:    wr = '{addr: ADDR_BW,    data: 32'd7};
            4'd8:    wr = '{addr: ADDR_START, data: 32'd0};
            4'd9:    wr = '{addr: ADDR_MODE,  data: 32'd0};
            4'd10:   wr = '{addr: ADDR_PHASE, data: ph_word};
            4'd11:   wr = '{addr: ADDR_START, data: 32'd0};
            default: wr = '{addr: ADDR_MODE,  data: 32'd0};
        endcase
    end

    assign accept  = (state == ISSUE) && !mgmt_waitrequest;
    assign lock_ok = (state == WAIT_LOCK) && locked;
    assign tmo     = (state == WAIT_LOCK) && !locked && (LOCK_TIMEOUT != 0) && (cnt == 32'd0);

    always_comb begin
        state_nx = state;
        step_nx  = step;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req) begin
                state_nx = GAP;
                cnt_nx   = 32'd0;
                step_nx  = phase_only ? STEP_PH0 : 4'd0;
            end
            ISSUE: if (accept) begin
                state_nx = GAP;
                cnt_nx   = GAP_LD;
                step_nx  = step + 4'd1;
            end
            // A zero count also serves as the one-cycle decision slot after req
            GAP: begin
                if (cnt != 32'd0)
                    cnt_nx = cnt - 32'd1;
                else if (step == STEP_PH0 && !ph_mode) begin
                    state_nx = PLLRST;
                    cnt_nx   = RST_LD;
                end else if (step == STEP_PH0)
                    state_nx = delta_zero ? DONE : ISSUE;
                else if (step == STEP_END)
                    state_nx = DONE;
                else
                    state_nx = ISSUE;
            end
            PLLRST: begin
                if (cnt != 32'd0)
                    cnt_nx = cnt - 32'd1;
                else begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = LOCK_LD;
                end
            end
            WAIT_LOCK: begin
                if (lock_ok)
                    state_nx = delta_zero ? DONE : ISSUE;
                else if (tmo)
                    state_nx = DONE;
                else if (cnt != 32'd0)
                    cnt_nx = cnt - 32'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step      <= 4'd0;
            cnt       <= 32'd0;
            m_q       <= 32'd0;
            k_q       <= 32'd0;
            c_q       <= 32'd0;
            ph_q      <= '0;
            ph_mode   <= 1'b0;
            err       <= 1'b0;
            cur_phase <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req) begin
                m_q     <= cfg_m;
                k_q     <= cfg_k;
                c_q     <= cfg_c;
                ph_q    <= cfg_phase;
                ph_mode <= phase_only;
                err     <= 1'b0;
            end
            if (lock_ok)
                ph_mode <= 1'b1;
            if (tmo)
                err <= 1'b1;
            if (accept && step == STEP_PH2)
                cur_phase <= ph_q;
        end
    end

    assign mgmt_write     = (state == ISSUE);
    assign mgmt_address   = wr.addr;
    assign mgmt_writedata = wr.data;
    assign pll_reset      = (state == PLLRST);
    assign busy           = (state == ISSUE) || (state == GAP) || (state == PLLRST) || (state == WAIT_LOCK);
    assign done           = (state == DONE);

endmodule

// File: tb/tb_pll_recfg_seq.sv
// Scoreboard bench for pll_recfg_seq: stimulus pushes expected writes/done events, a monitor pops and compares.
module tb_pll_recfg_seq;

    localparam int GAP = 7;
    localparam int RST = 8;
    localparam int LTO = 100;
    localparam int PW  = 16;

    logic          clk = 1'b0;
    logic          reset, req, phase_only, locked, mgmt_waitrequest;
    logic [31:0]   cfg_m, cfg_k, cfg_c;
    logic [PW-1:0] cfg_phase;
    logic          mgmt_write, pll_reset, busy, done, err;
    logic [5:0]    mgmt_address;
    logic [31:0]   mgmt_writedata;
    logic [PW-1:0] cur_phase;

    always #10 clk = ~clk;

    pll_recfg_seq #(
        .GAP_CYCLES(GAP), .RST_CYCLES(RST), .LOCK_TIMEOUT(LTO), .PH_W(PW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .phase_only(phase_only),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c), .cfg_phase(cfg_phase),
        .locked(locked), .mgmt_waitrequest(mgmt_waitrequest),
        .mgmt_write(mgmt_write), .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .pll_reset(pll_reset), .busy(busy), .done(done), .err(err), .cur_phase(cur_phase)
    );

    typedef struct { logic [5:0] a; logic [31:0] d; bit g; } wr_e;
    typedef struct { bit e; logic [PW-1:0] ph; int kind; int lat; } dn_e;

    wr_e wq[$];
    dn_e dq[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  req_cyc = 0;
    bit  pr_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tmo_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    task automatic pw(input logic [5:0] a, input logic [31:0] d, input bit g);
        wr_e e;
        e.a = a; e.d = d; e.g = g;
        wq.push_back(e);
    endtask

    task automatic pd(input bit e, input logic [PW-1:0] ph, input int kind, input int lat);
        dn_e x;
        x.e = e; x.ph = ph; x.kind = kind; x.lat = lat;
        dq.push_back(x);
    endtask

    // Frequency list with C1 given explicitly so the expected word is hand-written
    task automatic push_freq(input logic [31:0] m, k, c, c1);
        pw(6'd0, 32'd0, 1'b0);
        pw(6'd4, m, 1'b1);
        pw(6'd7, k, 1'b1);
        pw(6'd3, 32'h10000, 1'b1);
        pw(6'd5, c, 1'b1);
        pw(6'd5, c1, 1'b1);
        pw(6'd9, 32'd1, 1'b1);
        pw(6'd8, 32'd7, 1'b1);
        pw(6'd2, 32'd0, 1'b1);
    endtask

    task automatic push_phase(input logic [31:0] w6);
        pw(6'd0, 32'd0, 1'b0);
        pw(6'd6, w6, 1'b1);
        pw(6'd2, 32'd0, 1'b1);
    endtask

    task automatic issue(input bit po, input logic [31:0] m, k, c, input logic [PW-1:0] ph);
        @(posedge clk); #1;
        phase_only = po; cfg_m = m; cfg_k = k; cfg_c = c; cfg_phase = ph;
        req = 1'b1;
        req_cyc = cyc;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) tmo_fail("wait_done");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_prst_rise(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (pll_reset) begin seen = 1'b1; break; end
        end
        if (!seen) tmo_fail("wait_pll_reset_rise");
    endtask

    task automatic lock_after(input int d);
        bit seen = 1'b0;
        wait_prst_rise(400);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!pll_reset) begin seen = 1'b1; break; end
        end
        if (!seen) tmo_fail("wait_pll_reset_fall");
        repeat (d) @(posedge clk);
        #1 locked = 1'b1;
    endtask

    // Monitor: pops scoreboard entries on accepted writes and done pulses
    initial begin
        logic       prev_wr = 1'b0, prev_pr = 1'b0;
        int         rise_cyc = 0, acc_cyc = 0, fall_cyc = 0, pr_len = 0, stalls = 0;
        logic [5:0] st_a = '0;
        logic [31:0] st_d = '0;
        bit         stable = 1'b1;
        wr_e        e;
        dn_e        x;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wr = 1'b0; prev_pr = 1'b0; pr_len = 0; stalls = 0;
            end else begin
                if (mgmt_write && !prev_wr) begin
                    rise_cyc = cyc; st_a = mgmt_address; st_d = mgmt_writedata;
                    stable = 1'b1; stalls = 0;
                end
                if (mgmt_write && (mgmt_address !== st_a || mgmt_writedata !== st_d)) stable = 1'b0;
                if (mgmt_write && mgmt_waitrequest) stalls++;
                if (mgmt_write && !mgmt_waitrequest) begin
                    if (wq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, want none", mgmt_address, mgmt_writedata);
                    end else begin
                        e = wq.pop_front();
                        chk("wr_addr", 64'(mgmt_address), 64'(e.a));
                        chk("wr_data", 64'(mgmt_writedata), 64'(e.d));
                        if (e.g) chk("wr_gap", 64'(rise_cyc - acc_cyc - 1), 64'(GAP));
                        if (stalls > 0) chk("stall_stable", 64'(stable), 64'd1);
                    end
                    acc_cyc = cyc;
                end
                if (pll_reset) pr_len++;
                else if (prev_pr) begin
                    fall_cyc = cyc;
                    if (pr_chk) chk("prst_width", 64'(pr_len), 64'(RST));
                    pr_len = 0;
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
                    end else begin
                        x = dq.pop_front();
                        chk("done_busy", 64'(busy), 64'd0);
                        chk("done_err", 64'(err), 64'(x.e));
                        chk("done_phase", 64'(cur_phase), 64'(x.ph));
                        if (x.kind == 1) chk("lat_req", 64'(cyc - req_cyc), 64'(x.lat));
                        if (x.kind == 2) chk("lat_fall", 64'(cyc - fall_cyc), 64'(x.lat));
                    end
                end
                prev_wr = mgmt_write;
                prev_pr = pll_reset;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; req = 1'b0; phase_only = 1'b0; locked = 1'b0; mgmt_waitrequest = 1'b0;
        cfg_m = '0; cfg_k = '0; cfg_c = '0; cfg_phase = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", 64'(mgmt_write), 64'd0);
        chk("rst_prst", 64'(pll_reset), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_phase", 64'(cur_phase), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: full frequency retune, then phase 0 -> 29
        push_freq(32'h808, 32'hB33332DD, 32'h20302, 32'h60302);
        push_phase(32'h1001D);
        pd(1'b0, 16'd29, 0, 0);
        issue(1'b0, 32'h808, 32'hB33332DD, 32'h20302, 16'd29);
        #1 chk("busy_after_req", 64'(busy), 64'd1);
        lock_after(3);
        wait_done(400);
        locked = 1'b0;

        // 2: phase only, 29 -> 20 (negative step)
        push_phase(32'h210009);
        pd(1'b0, 16'd20, 1, 26);
        issue(1'b1, 32'h0, 32'h0, 32'h0, 16'd20);
        wait_done(100);

        // 3: phase only with no change: no writes
        pd(1'b0, 16'd20, 1, 2);
        issue(1'b1, 32'h0, 32'h0, 32'h0, 16'd20);
        wait_done(20);

        // 4: waitrequest stall on the K write, phase 20 -> 25
        push_freq(32'h404, 32'h1234, 32'h10101, 32'h50101);
        push_phase(32'h10005);
        pd(1'b0, 16'd25, 0, 0);
        issue(1'b0, 32'h404, 32'h1234, 32'h10101, 16'd25);
        n = -1;
        for (int i = 0; i < 100; i++) begin
            if (mgmt_address == 6'd7) begin n = 0; break; end
            @(posedge clk); #1;
        end
        if (n < 0) tmo_fail("wait_k_addr");
        mgmt_waitrequest = 1'b1;
        for (int i = 0; i < 200 && n < 50; i++) begin
            @(posedge clk); #1;
            if (mgmt_write) n++;
        end
        if (n < 50) tmo_fail("k_stall");
        mgmt_waitrequest = 1'b0;
        lock_after(2);
        wait_done(400);
        locked = 1'b0;

        // 5: lock timeout: err, no phase writes, cur_phase unchanged
        push_freq(32'h808, 32'hB33332DD, 32'h20302, 32'h60302);
        pd(1'b1, 16'd25, 2, 100);
        issue(1'b0, 32'h808, 32'hB33332DD, 32'h20302, 16'd100);
        wait_done(400);
        chk("err_sticky", 64'(err), 64'd1);
        chk("phase_kept", 64'(cur_phase), 64'd25);

        // 6b: second req mid-sequence is ignored; this req clears err
        push_phase(32'h1000F);
        pd(1'b0, 16'd40, 1, 26);
        issue(1'b1, 32'h0, 32'h0, 32'h0, 16'd40);
        #1 chk("err_cleared", 64'(err), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        req = 1'b1; phase_only = 1'b0; cfg_m = 32'd99; cfg_phase = 16'd3;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(100);

        // 6a: reset during the PLL reset pulse
        push_freq(32'h808, 32'hB33332DD, 32'h20302, 32'h60302);
        issue(1'b0, 32'h808, 32'hB33332DD, 32'h20302, 16'd7);
        wait_prst_rise(400);
        repeat (2) @(posedge clk);
        #1;
        pr_chk = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_prst", 64'(pll_reset), 64'd0);
        chk("mid_rst_write", 64'(mgmt_write), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_phase", 64'(cur_phase), 64'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pr_chk = 1'b1;
        chk("post_rst_idle", 64'(busy), 64'd0);

        chk("wr_queue_empty", 64'(wq.size()), 64'd0);
        chk("done_queue_empty", 64'(dq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
